// File: rtl/bus_arbiter_2m_pkg.sv
// Shared definitions for the two-master bus arbiter: state encoding,
// owner encoding and default bus widths.
package bus_arbiter_2m_pkg;

    // Default widths, matching the downstream 1-master/2-slave bus.
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    // Arbiter FSM state encoding. Kept as plain constants so older code
    // that compares against raw 2-bit values still lines up.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_GNT0 = 2'b01;
    localparam logic [1:0] ST_GNT1 = 2'b10;

    // Which master a bus cycle belongs to, used to steer read data back.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_t;

    // Map an FSM state onto the master that owns the bus in that state.
    function automatic owner_t owner_of(input logic [1:0] st);
        owner_t own;
        own = OWN_NONE;
        if (st == ST_GNT0) begin
            own = OWN_M0;
        end else if (st == ST_GNT1) begin
            own = OWN_M1;
        end
        return own;
    endfunction

endpackage

// File: rtl/bus_arbiter_2m_arb_master_mux.sv
// 2:1 master-signal multiplexer. Forwards the selected master's write
// enable, address and write data; with neither selected everything is
// zero so the bus never sees a stray write.
module arb_master_mux
    import bus_arbiter_2m_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              sel0,
    input  logic              sel1,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_dout,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_dout,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_dout
);

    // Pick the selected master's signals, zero when the bus is idle.
    always_comb begin
        bus_wr   = 1'b0;
        bus_addr = '0;
        bus_dout = '0;
        if (sel0) begin
            bus_wr   = m0_wr;
            bus_addr = m0_addr;
            bus_dout = m0_dout;
        end else if (sel1) begin
            bus_wr   = m1_wr;
            bus_addr = m1_addr;
            bus_dout = m1_dout;
        end
    end

endmodule

// File: rtl/bus_arbiter_2m.sv
// Two-master round-robin arbiter with bounded hold time, sitting in front
// of the single-master bus. Drives the bus master port from the granted
// master and returns read data to whichever master issued the access.
module bus_arbiter_2m
    import bus_arbiter_2m_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              M0_req,
    input  logic              M0_wr,
    input  logic [ADDR_W-1:0] M0_addr,
    input  logic [DATA_W-1:0] M0_dout,
    input  logic              M1_req,
    input  logic              M1_wr,
    input  logic [ADDR_W-1:0] M1_addr,
    input  logic [DATA_W-1:0] M1_dout,
    output logic              M0_grant,
    output logic              M1_grant,
    output logic [DATA_W-1:0] M0_din,
    output logic [DATA_W-1:0] M1_din,
    output logic              B_req,
    output logic              B_wr,
    output logic [ADDR_W-1:0] B_addr,
    output logic [DATA_W-1:0] B_dout,
    input  logic              B_grant,
    input  logic [DATA_W-1:0] B_din
);

    // Preemption is only active for a non-zero hold limit; HOLD_LAST is the
    // counter value at which the owner has used up its time slice.
    localparam bit               HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             last;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_next;
    owner_t           owner_d;
    logic             slice_done;

    assign slice_done = HOLD_EN && (hold_cnt == HOLD_LAST);

    // Next-state decision: round-robin on ties, direct hand-over when the
    // owner lets go while the other waits, preemption when the slice ends.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (M0_req && M1_req) begin
                    state_next = last ? ST_GNT0 : ST_GNT1;
                end else if (M0_req) begin
                    state_next = ST_GNT0;
                end else if (M1_req) begin
                    state_next = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (!M0_req) begin
                    state_next = M1_req ? ST_GNT1 : ST_IDLE;
                end else if (M1_req && slice_done) begin
                    state_next = ST_GNT1;
                end
            end
            ST_GNT1: begin
                if (!M1_req) begin
                    state_next = M0_req ? ST_GNT0 : ST_IDLE;
                end else if (M0_req && slice_done) begin
                    state_next = ST_GNT0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Hold counter: restarts on every state change, counts while the owner
    // keeps requesting, and parks at the last slot of the slice.
    always_comb begin
        hold_cnt_next = hold_cnt;
        if (state_next != state) begin
            hold_cnt_next = '0;
        end else if (HOLD_EN && !slice_done &&
                     (((state == ST_GNT0) && M0_req) ||
                      ((state == ST_GNT1) && M1_req))) begin
            hold_cnt_next = hold_cnt + 1'b1;
        end
    end

    // State, round-robin memory, hold counter and read-return owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            last     <= 1'b1;
            hold_cnt <= '0;
            owner_d  <= OWN_NONE;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
            owner_d  <= owner_of(state);
            if (state_next != state) begin
                if (state_next == ST_GNT0) begin
                    last <= 1'b0;
                end else if (state_next == ST_GNT1) begin
                    last <= 1'b1;
                end
            end
        end
    end

    assign B_req    = (state != ST_IDLE);
    assign M0_grant = (state == ST_GNT0) && B_grant;
    assign M1_grant = (state == ST_GNT1) && B_grant;

    arb_master_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bus_mux (
        .sel0     (state == ST_GNT0),
        .sel1     (state == ST_GNT1),
        .m0_wr    (M0_wr),
        .m0_addr  (M0_addr),
        .m0_dout  (M0_dout),
        .m1_wr    (M1_wr),
        .m1_addr  (M1_addr),
        .m1_dout  (M1_dout),
        .bus_wr   (B_wr),
        .bus_addr (B_addr),
        .bus_dout (B_dout)
    );

    // Read data goes only to the master that owned the previous bus cycle,
    // lining up with the bus's registered slave-select path.
    always_comb begin
        M0_din = (owner_d == OWN_M0) ? B_din : '0;
        M1_din = (owner_d == OWN_M1) ? B_din : '0;
    end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Directed testbench for bus_arbiter_2m. Three arbiters with hold limits
// 16, 4 and 0 share the master inputs; each has its own small bus model
// whose grant follows B_req one cycle later.
module tb_bus_arbiter_2m;

    logic        clk;
    logic        reset;
    logic        M0_req, M0_wr, M1_req, M1_wr;
    logic [7:0]  M0_addr, M1_addr;
    logic [31:0] M0_dout, M1_dout;
    logic [31:0] bdin;

    logic        a_M0_grant, a_M1_grant, a_B_req, a_B_wr, a_B_grant;
    logic [31:0] a_M0_din, a_M1_din, a_B_dout;
    logic [7:0]  a_B_addr;
    logic        b_M0_grant, b_M1_grant, b_B_req, b_B_wr, b_B_grant;
    logic [31:0] b_M0_din, b_M1_din, b_B_dout;
    logic [7:0]  b_B_addr;
    logic        c_M0_grant, c_M1_grant, c_B_req, c_B_wr, c_B_grant;
    logic [31:0] c_M0_din, c_M1_din, c_B_dout;
    logic [7:0]  c_B_addr;

    int vectors;
    int miscompares;

    bus_arbiter_2m #(.ADDR_W(8), .DATA_W(32), .MAX_HOLD(16), .CNT_W(5)) dut16 (
        .clk(clk), .reset(reset),
        .M0_req(M0_req), .M0_wr(M0_wr), .M0_addr(M0_addr), .M0_dout(M0_dout),
        .M1_req(M1_req), .M1_wr(M1_wr), .M1_addr(M1_addr), .M1_dout(M1_dout),
        .M0_grant(a_M0_grant), .M1_grant(a_M1_grant),
        .M0_din(a_M0_din), .M1_din(a_M1_din),
        .B_req(a_B_req), .B_wr(a_B_wr), .B_addr(a_B_addr), .B_dout(a_B_dout),
        .B_grant(a_B_grant), .B_din(bdin)
    );

    bus_arbiter_2m #(.ADDR_W(8), .DATA_W(32), .MAX_HOLD(4), .CNT_W(5)) dut4 (
        .clk(clk), .reset(reset),
        .M0_req(M0_req), .M0_wr(M0_wr), .M0_addr(M0_addr), .M0_dout(M0_dout),
        .M1_req(M1_req), .M1_wr(M1_wr), .M1_addr(M1_addr), .M1_dout(M1_dout),
        .M0_grant(b_M0_grant), .M1_grant(b_M1_grant),
        .M0_din(b_M0_din), .M1_din(b_M1_din),
        .B_req(b_B_req), .B_wr(b_B_wr), .B_addr(b_B_addr), .B_dout(b_B_dout),
        .B_grant(b_B_grant), .B_din(bdin)
    );

    bus_arbiter_2m #(.ADDR_W(8), .DATA_W(32), .MAX_HOLD(0), .CNT_W(5)) dut0 (
        .clk(clk), .reset(reset),
        .M0_req(M0_req), .M0_wr(M0_wr), .M0_addr(M0_addr), .M0_dout(M0_dout),
        .M1_req(M1_req), .M1_wr(M1_wr), .M1_addr(M1_addr), .M1_dout(M1_dout),
        .M0_grant(c_M0_grant), .M1_grant(c_M1_grant),
        .M0_din(c_M0_din), .M1_din(c_M1_din),
        .B_req(c_B_req), .B_wr(c_B_wr), .B_addr(c_B_addr), .B_dout(c_B_dout),
        .B_grant(c_B_grant), .B_din(bdin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus models: grant is B_req delayed by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_B_grant <= 1'b0;
            b_B_grant <= 1'b0;
            c_B_grant <= 1'b0;
        end else begin
            a_B_grant <= a_B_req;
            b_B_grant <= b_B_req;
            c_B_grant <= c_B_req;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset over one edge, then release just after it so the next
    // rising edge is the first functional one.
    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        M0_req = 1'b1; M0_wr = 1'b0; M0_addr = 8'h11; M0_dout = 32'h0;
        M1_req = 1'b1; M1_wr = 1'b0; M1_addr = 8'h22; M1_dout = 32'h0;
        bdin = 32'h1234_5678;
        reset = 1'b1;
        step();
        vectors++;
        if ({a_B_req, a_B_wr, a_M0_grant, a_M1_grant} !== 4'b0000 ||
            a_B_addr !== 8'h00 || a_M0_din !== 32'h0 || a_M1_din !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: req=%b wr=%b g0=%b g1=%b addr=%h d0=%h d1=%h, want all 0",
                     a_B_req, a_B_wr, a_M0_grant, a_M1_grant, a_B_addr, a_M0_din, a_M1_din);
        end
        reset = 1'b0;
        step();
        vectors++;
        if (a_B_req !== 1'b1 || a_B_addr !== 8'h11 || a_M0_grant !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_first_grant: req=%b addr=%h g0=%b, want 1 11 0",
                     a_B_req, a_B_addr, a_M0_grant);
        end
        step();
        vectors++;
        if (a_M0_grant !== 1'b1 || a_M1_grant !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_bus_grant: g0=%b g1=%b, want 1 0", a_M0_grant, a_M1_grant);
        end
    endtask

    task automatic test_handover();
        M0_req = 1'b1; M0_wr = 1'b1; M0_addr = 8'h05; M0_dout = 32'hDEADBEEF;
        M1_req = 1'b0; M1_wr = 1'b0; M1_addr = 8'h22; M1_dout = 32'h0;
        pulse_reset();
        step();
        vectors++;
        if (a_B_req !== 1'b1 || a_B_wr !== 1'b1 || a_B_addr !== 8'h05 || a_B_dout !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL handover_m0_write: req=%b wr=%b addr=%h dout=%h, want 1 1 05 deadbeef",
                     a_B_req, a_B_wr, a_B_addr, a_B_dout);
        end
        step();
        vectors++;
        if (a_M0_grant !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL handover_m0_grant: got %b want 1", a_M0_grant);
        end
        M0_req = 1'b0;
        M1_req = 1'b1;
        bdin = 32'hAAAA_0001;
        step();
        vectors++;
        if (a_B_req !== 1'b1 || a_B_wr !== 1'b0 || a_B_addr !== 8'h22 ||
            a_M1_grant !== 1'b1 || a_M0_grant !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL handover_switch: req=%b wr=%b addr=%h g0=%b g1=%b, want 1 0 22 0 1",
                     a_B_req, a_B_wr, a_B_addr, a_M0_grant, a_M1_grant);
        end
        vectors++;
        if (a_M0_din !== 32'hAAAA_0001 || a_M1_din !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL handover_m0_tail: d0=%h d1=%h, want aaaa0001 0", a_M0_din, a_M1_din);
        end
        bdin = 32'hCAFE_F00D;
        step();
        vectors++;
        if (a_M1_din !== 32'hCAFE_F00D || a_M0_din !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL handover_m1_read: d1=%h d0=%h, want cafef00d 0", a_M1_din, a_M0_din);
        end
        M1_req = 1'b0;
        step();
        vectors++;
        if (a_B_req !== 1'b0 || a_B_addr !== 8'h00 || a_M1_grant !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL handover_idle: req=%b addr=%h g1=%b, want 0 00 0",
                     a_B_req, a_B_addr, a_M1_grant);
        end
        step();
        vectors++;
        if (a_M1_din !== 32'h0 || a_M0_din !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL handover_din_idle: d0=%h d1=%h, want 0 0", a_M0_din, a_M1_din);
        end
    endtask

    // Both masters request forever: limit 4 alternates every 4 cycles,
    // limit 16 every 16 cycles, limit 0 never lets go of master 0.
    task automatic test_preemption();
        logic [7:0] exp_a, exp_b;
        logic       exp_g0b;
        M0_req = 1'b1; M0_wr = 1'b1; M0_addr = 8'h11; M0_dout = 32'h1;
        M1_req = 1'b1; M1_wr = 1'b0; M1_addr = 8'h22; M1_dout = 32'h2;
        pulse_reset();
        for (int k = 1; k <= 100; k++) begin
            step();
            exp_b   = (((k - 1) / 4) % 2 == 0) ? 8'h11 : 8'h22;
            exp_a   = (((k - 1) / 16) % 2 == 0) ? 8'h11 : 8'h22;
            exp_g0b = (k >= 2) && (exp_b == 8'h11);
            vectors++;
            if (b_B_addr !== exp_b || b_M0_grant !== exp_g0b || b_M1_grant !== ((k >= 2) && !exp_g0b)) begin
                miscompares++;
                $display("[TB] FAIL hold4_cycle%0d: addr=%h g0=%b g1=%b, want addr=%h g0=%b",
                         k, b_B_addr, b_M0_grant, b_M1_grant, exp_b, exp_g0b);
            end
            vectors++;
            if (a_B_addr !== exp_a) begin
                miscompares++;
                $display("[TB] FAIL hold16_cycle%0d: addr=%h want %h", k, a_B_addr, exp_a);
            end
            vectors++;
            if (c_B_addr !== 8'h11 || c_M0_grant !== (k >= 2) || c_M1_grant !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL hold0_cycle%0d: addr=%h g0=%b g1=%b, want 11 %b 0",
                         k, c_B_addr, c_M0_grant, c_M1_grant, (k >= 2));
            end
        end
    endtask

    task automatic test_saturate();
        M0_req = 1'b0; M0_wr = 1'b0; M0_addr = 8'h11;
        M1_req = 1'b1; M1_wr = 1'b1; M1_addr = 8'h33; M1_dout = 32'h55;
        pulse_reset();
        for (int k = 1; k <= 40; k++) begin
            step();
            vectors++;
            if (a_B_addr !== 8'h33 || a_M1_grant !== (k >= 2)) begin
                miscompares++;
                $display("[TB] FAIL single_m1_cycle%0d: addr=%h g1=%b, want 33 %b",
                         k, a_B_addr, a_M1_grant, (k >= 2));
            end
        end
        vectors++;
        if (dut16.hold_cnt !== 5'd15) begin
            miscompares++;
            $display("[TB] FAIL hold_cnt_saturate: got %0d want 15", dut16.hold_cnt);
        end
    endtask

    task automatic test_reset_mid();
        M0_req = 1'b0;
        M1_req = 1'b1; M1_wr = 1'b1; M1_addr = 8'h44; M1_dout = 32'h77;
        bdin = 32'hBEEF_0001;
        pulse_reset();
        step();
        step();
        step();
        vectors++;
        if (a_M1_grant !== 1'b1 || a_M1_din !== 32'hBEEF_0001 || a_B_wr !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midreset_pre: g1=%b d1=%h wr=%b, want 1 beef0001 1",
                     a_M1_grant, a_M1_din, a_B_wr);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({a_B_req, a_B_wr, a_M0_grant, a_M1_grant} !== 4'b0000 ||
            a_B_addr !== 8'h00 || a_M1_din !== 32'h0 || a_M0_din !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset_async: req=%b wr=%b g0=%b g1=%b addr=%h d1=%h, want all 0",
                     a_B_req, a_B_wr, a_M0_grant, a_M1_grant, a_B_addr, a_M1_din);
        end
        step();
        reset = 1'b0;
        step();
        vectors++;
        if (a_B_req !== 1'b1 || a_B_addr !== 8'h44 || a_M1_grant !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_regrant: req=%b addr=%h g1=%b, want 1 44 0",
                     a_B_req, a_B_addr, a_M1_grant);
        end
        step();
        vectors++;
        if (a_M1_grant !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midreset_bus_grant: got %b want 1", a_M1_grant);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        M0_req = 1'b0; M0_wr = 1'b0; M0_addr = '0; M0_dout = '0;
        M1_req = 1'b0; M1_wr = 1'b0; M1_addr = '0; M1_dout = '0;
        bdin = '0;
        test_reset();
        test_handover();
        test_preemption();
        test_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
